// File: rtl/square_plot_sequencer_pkg.sv
// Shared definitions for the square plot sequencer: FSM encoding and screen widths.
// No logic; types and constants only.
// Imported by the sequencer top, its pixel counter and the testbench.
package square_plot_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    // Drawing a square in black erases it.
    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/square_plot_sequencer_counter.sv
// Pixel index counter for one square: clear on request accept, +1 per accepted pixel.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: holds its value whenever i_en is low.
module square_pixel_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Clear takes priority so a fresh square always starts at pixel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = &r_cnt;

endmodule

// File: rtl/square_plot_sequencer.sv
// Walks a 2^SIDE_LOG2 square in raster order, one plot strobe per pixel toward the VGA adapter.
// Latency: first pixel the cycle after accept; done one cycle after the last pixel; ready one after done.
// Backpressure: plot outputs hold while plot_ready=0; requests are refused (req_ready=0) while busy.
module square_plot_sequencer
    import square_plot_sequencer_pkg::*;
#(
    parameter int SIDE_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic                plot_en,
    input  logic                plot_ready,
    output logic [X_W-1:0]      plot_x,
    output logic [Y_W-1:0]      plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = 2 * SIDE_LOG2;

    state_t                r_state;
    logic                  r_req_ready;
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    logic [COLOUR_W-1:0]   r_colour;

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_last;
    logic                  w_draw;
    logic                  w_accept;
    logic                  w_xfer;
    logic [SIDE_LOG2-1:0]  w_col;
    logic [SIDE_LOG2-1:0]  w_row;

    assign w_draw   = (r_state == ST_DRAW);
    assign w_accept = r_req_ready & req_valid;
    assign w_xfer   = w_draw & plot_ready;
    assign w_col    = w_cnt[SIDE_LOG2-1:0];
    assign w_row    = w_cnt[CNT_W-1:SIDE_LOG2];

    square_pixel_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_accept),
        .i_en   (w_xfer),
        .o_cnt  (w_cnt),
        .o_last (w_last)
    );

    // Sequencer FSM; req_ready is its own register so it stays low through reset
    // and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_colour    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x         <= req_x;
                        r_y         <= req_y;
                        r_colour    <= req_colour;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_DRAW;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (w_xfer && w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registers only; plot bus parks at zero outside DRAW.
    always_comb begin
        req_ready   = r_req_ready;
        plot_en     = w_draw;
        busy        = (r_state == ST_DRAW) || (r_state == ST_DONE);
        done        = (r_state == ST_DONE);
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = '0;
        if (w_draw) begin
            plot_x      = r_x + {{(X_W - SIDE_LOG2){1'b0}}, w_col};
            plot_y      = r_y + {{(Y_W - SIDE_LOG2){1'b0}}, w_row};
            plot_colour = r_colour;
        end
    end

endmodule

// File: tb/tb_square_plot_sequencer.sv
// Self-checking bench: two sequencers (4x4 and 2x2) against a raster-order pixel list model.
// Directed draws, stalls, busy rejection, wrap-around, mid-square reset, then random squares.
// Inputs driven on the falling edge, outputs sampled there too.
module tb_square_plot_sequencer;
    import square_plot_sequencer_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  rv;
    logic [7:0]  req_x;
    logic [6:0]  req_y;
    logic [2:0]  req_colour;
    logic        plot_ready;

    logic [1:0]  o_rdy, o_en, o_busy, o_done;
    logic [7:0]  o_px [2];
    logic [6:0]  o_py [2];
    logic [2:0]  o_pc [2];

    int n_chk  = 0;
    int n_pass = 0;

    square_plot_sequencer #(.SIDE_LOG2(2)) dut (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(o_rdy[0]),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .plot_en(o_en[0]), .plot_ready(plot_ready), .plot_x(o_px[0]), .plot_y(o_py[0]),
        .plot_colour(o_pc[0]), .busy(o_busy[0]), .done(o_done[0])
    );

    square_plot_sequencer #(.SIDE_LOG2(1)) dut_small (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(o_rdy[1]),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .plot_en(o_en[1]), .plot_ready(plot_ready), .plot_x(o_px[1]), .plot_y(o_py[1]),
        .plot_colour(o_pc[1]), .busy(o_busy[1]), .done(o_done[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // k-th pixel of a square in raster order, x fastest, coordinates wrap at 8/7 bits.
    function automatic logic [17:0] exp_pix(input logic [7:0] x, input logic [6:0] y,
                                            input logic [2:0] c, input int k, input int side);
        logic [7:0] ex;
        logic [6:0] ey;
        ex = x + 8'(k % side);
        ey = y + 7'(k / side);
        return {ex, ey, c};
    endfunction

    // mode 0: plot_ready always 1; 1: 2-cycle stalls on pixels 3 and 7; 2: random ready.
    // hold: keep req_valid up after accept with (hx,hy,hc) as the next request.
    task automatic run_square(input int s, input logic [7:0] x, input logic [6:0] y,
                              input logic [2:0] col, input int mode, input bit hold,
                              input logic [7:0] hx, input logic [6:0] hy, input logic [2:0] hc);
        int side, n, idx, cyc, stalls, stall_left, guard;
        bit stalled2, stalled6, rdy;
        side = (s == 1) ? 2 : 4;
        n = side * side;
        req_x = x; req_y = y; req_colour = col;
        rv[s] = 1'b1;
        guard = 0;
        while (!o_rdy[s] && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        chk("req_ready_idle", o_rdy[s], 1);
        @(posedge clk);
        @(negedge clk);
        if (hold) begin
            req_x = hx; req_y = hy; req_colour = hc;
        end else begin
            rv[s] = 1'b0;
        end
        idx = 0; cyc = 0; stalls = 0; stall_left = 0; guard = 0;
        stalled2 = 0; stalled6 = 0;
        while (idx < n && guard < 400) begin
            cyc++;
            chk("plot_en", o_en[s], 1);
            chk("busy_draw", o_busy[s], 1);
            chk("ready_busy", o_rdy[s], 0);
            chk("done_draw", o_done[s], 0);
            chk("pixel", {o_px[s], o_py[s], o_pc[s]}, exp_pix(x, y, col, idx, side));
            if (mode == 1) begin
                if (idx == 2 && !stalled2) begin stalled2 = 1; stall_left = 2; end
                if (idx == 6 && !stalled6) begin stalled6 = 1; stall_left = 2; end
                rdy = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end else if (mode == 2) begin
                rdy = ($urandom % 4) != 0;
            end else begin
                rdy = 1'b1;
            end
            if (!rdy) stalls++;
            plot_ready = rdy;
            @(posedge clk);
            if (rdy) idx++;
            @(negedge clk);
            guard++;
        end
        if (idx < n) chk("draw_timeout", idx, n);
        cyc++;
        chk("done_pulse", o_done[s], 1);
        chk("done_plot_en", o_en[s], 0);
        chk("done_busy", o_busy[s], 1);
        chk("done_ready", o_rdy[s], 0);
        chk("done_cycle", cyc, n + stalls + 1);
        plot_ready = 1'($urandom % 2);
        @(negedge clk);
        chk("done_one_cycle", o_done[s], 0);
        chk("ready_after_done", o_rdy[s], 1);
        chk("idle_busy", o_busy[s], 0);
    endtask

    task automatic reset_mid_square();
        req_x = 8'd30; req_y = 7'd40; req_colour = 3'b011;
        rv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[0] = 1'b0;
        plot_ready = 1'b1;
        chk("mid_pixel0", {o_px[0], o_py[0], o_pc[0]}, exp_pix(8'd30, 7'd40, 3'b011, 0, 4));
        repeat (5) @(posedge clk);
        #2;
        chk("mid_pixel5", {o_px[0], o_py[0], o_pc[0]}, exp_pix(8'd30, 7'd40, 3'b011, 5, 4));
        reset = 1'b1;
        #1;
        chk("rst_plot_en", o_en[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_ready", o_rdy[0], 0);
        chk("rst_done", o_done[0], 0);
        chk("rst_plot_bus", {o_px[0], o_py[0], o_pc[0]}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_ready_low", o_rdy[0], 0);
        @(negedge clk);
        chk("rel_ready_high", o_rdy[0], 1);
        chk("rel_no_done", o_done[0], 0);
        chk("rel_plot_en", o_en[0], 0);
    endtask

    initial begin
        reset = 1'b1;
        rv = 2'b00;
        req_x = '0; req_y = '0; req_colour = '0;
        plot_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_ready", o_rdy[s], 0);
            chk("reset_plot_en", o_en[s], 0);
            chk("reset_busy", o_busy[s], 0);
            chk("reset_done", o_done[s], 0);
            chk("reset_plot_bus", {o_px[s], o_py[s], o_pc[s]}, 0);
        end
        reset = 1'b0;
        #1;
        chk("release_ready_low", o_rdy[0], 0);
        @(negedge clk);
        chk("release_ready_high", o_rdy[0], 1);

        // Basic 4x4 draw, then the same with two 2-cycle stalls.
        run_square(0, 8'd10, 7'd20, 3'b100, 0, 0, 8'd0, 7'd0, 3'd0);
        run_square(0, 8'd10, 7'd20, 3'b100, 1, 0, 8'd0, 7'd0, 3'd0);
        // Request held through the whole draw with new data; accepted afterwards.
        run_square(0, 8'd10, 7'd20, 3'b100, 0, 1, 8'd50, 7'd20, 3'b100);
        run_square(0, 8'd50, 7'd20, 3'b100, 0, 0, 8'd0, 7'd0, 3'd0);
        // Coordinate wrap at both edges.
        run_square(0, 8'd254, 7'd126, 3'b010, 0, 0, 8'd0, 7'd0, 3'd0);
        // 2x2 erase.
        run_square(1, 8'd0, 7'd0, COLOUR_BLACK, 0, 0, 8'd0, 7'd0, 3'd0);
        reset_mid_square();

        for (int i = 0; i < 16; i++) begin
            run_square(int'($urandom % 2), 8'($urandom), 7'($urandom), 3'($urandom),
                       2, 0, 8'd0, 7'd0, 3'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/square_plot_sequencer.md
Name: square_plot_sequencer

Overview:
- Request-side controller for square drawing in the Simon Says VGA path.
- Accepts one draw request per square: origin (x, y) and colour, via a valid/ready handshake.
- Walks every pixel of a 2^SIDE_LOG2 x 2^SIDE_LOG2 square in raster order and emits one plot strobe per pixel toward the VGA adapter, honouring downstream backpressure.
- Signals completion with a one-cycle done pulse. Erasing a square is a request with colour 3'b000.

Parameters:
- SIDE_LOG2, 2, log2 of the square side in pixels (2 gives a 4x4 square, 16 pixels); legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  sequencer can accept a request.
- req_x  in  8  square origin x (left column).
- req_y  in  7  square origin y (top row).
- req_colour  in  3  RGB colour for the whole square.
- plot_en  out  1  current plot_x/plot_y/plot_colour is a valid pixel write.
- plot_ready  in  1  downstream accepts the pixel this cycle.
- plot_x  out  8  pixel x.
- plot_y  out  7  pixel y.
- plot_colour  out  3  pixel colour.
- busy  out  1  a square is in progress (DRAW or DONE).
- done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset: asynchronous, active-high.
  - State goes to IDLE; pixel counter, latched x/y/colour and done are all cleared to 0.
  - Outputs during reset: req_ready=0, plot_en=0, plot_x=0, plot_y=0, plot_colour=0, busy=0.
  - req_ready rises in the first cycle after reset deasserts.
- All outputs are decoded from registers only. There is no combinational path from inputs to outputs.
- State machine: IDLE -> DRAW -> DONE -> IDLE.
  - IDLE: req_ready=1, plot_en=0, busy=0. When req_valid=1, latch req_x, req_y and req_colour, clear the counter, and enter DRAW next cycle.
  - DRAW: req_ready=0, busy=1, plot_en=1.
    - plot_x = x_lat + cnt[SIDE_LOG2-1:0].
    - plot_y = y_lat + cnt[2*SIDE_LOG2-1:SIDE_LOG2].
    - plot_colour = colour_lat.
    - A pixel is transferred when plot_en and plot_ready are both 1. The counter increments only on a transfer.
    - While plot_ready=0, all plot outputs hold stable.
    - A transfer with cnt all-ones moves the FSM to DONE.
  - DONE: done=1 for exactly one cycle, busy=1, plot_en=0, req_ready=0. The FSM then returns to IDLE.
- Counter: 2*SIDE_LOG2 bits wide. It never wraps within a square, because the last transfer exits DRAW.
- Raster order: x varies fastest. The first pixel is (x_lat, y_lat) and the last is (x_lat+side-1, y_lat+side-1).
- Arithmetic: unsigned. x wraps modulo 256 and y wraps modulo 128. No clipping to the 160x120 screen; callers keep origins in range.
- Latency with plot_ready held at 1: request accepted at edge N; pixels on cycles N+1 .. N+2^(2*SIDE_LOG2); done on the following cycle; req_ready high one cycle after that.
  - For SIDE_LOG2=2: 16 pixel cycles, done on the 17th cycle after accept, ready on the 18th.
- Requests arriving while busy are not accepted. req_ready is 0; the requester must hold req_valid and its data.
- A reset asserted mid-square aborts the square immediately. No done pulse is produced, and the partial square stays on screen.
- A new request may be accepted on the IDLE cycle directly after DONE. There is no back-to-back accept in DONE.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, DRAW=2'd1, DONE=2'd2.
  - Screen-coordinate widths: X_W=8, Y_W=7, COLOUR_W=3.
  - COLOUR_BLACK=3'b000, used for erase.
- One natural sub-module, square_pixel_counter.
  - Enable-gated 2*SIDE_LOG2-bit counter with synchronous clear and a last flag.
  - Instantiated once; the top holds the FSM and the latches.

Test Plan:
- Basic draw:
  - Stimulus: reset, then req (x=10, y=20, colour=3'b100), plot_ready=1.
  - Response: 16 plot_en cycles at (10,20),(11,20),(12,20),(13,20),(10,21)…(13,23), all colour 100; done pulse on the 17th cycle; req_ready back on the 18th.
- Backpressure:
  - Stimulus: same request, with plot_ready low on pixels 3 and 7 for 2 cycles each.
  - Response: outputs hold (12,20) and (12,21) during the stalls; still exactly 16 transfers; done 4 cycles later than in the basic draw.
- Busy rejection:
  - Stimulus: req_valid held with new data (x=50) during DRAW.
  - Response: req_ready=0 and the first square completes unchanged; the held request is accepted in IDLE after done and drawn at x=50.
- Wrap-around:
  - Stimulus: req (x=254, y=126).
  - Response: x sequence 254,255,0,1 and y sequence 126,127,0,1; no hang.
- Reset mid-square:
  - Stimulus: assert reset asynchronously after pixel 5.
  - Response: plot_en=0, busy=0 and all outputs 0 immediately; no done pulse; req_ready=1 one cycle after release.
- Erase / parameter:
  - Stimulus: SIDE_LOG2=1, req colour 3'b000 at (0,0).
  - Response: 4 pixels (0,0),(1,0),(0,1),(1,1) with colour 000; done on the 5th cycle after accept.
